// File: rtl/alu_control.sv
// alu_control: registered ALU-control decoder.
// Combines the 2-bit ALUOp class from main control with the R-type funct
// field and registers a 3-bit ALU operation select, so the ALU sees a code
// that stays stable for the whole execute cycle.
//
// Interface: there is no handshake. The {ALUOp, funct} pair is sampled on
// every rising clock edge, and saida shows its decode from that edge
// onward. The only state is the 3-bit output register.
module alu_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] funct,
    input  logic [1:0] ALUOp,
    output logic [2:0] saida
);

    // ALU operation codes
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [2:0] next_code;

    // Decode {ALUOp, funct}. funct only matters for the R-type class (10).
    // Unknown R-type functs fall back to ADD; there is no error output.
    always_comb begin
        next_code = OP_ADD;
        casez ({ALUOp, funct})
            8'b00_??????: next_code = OP_ADD;   // load/store address
            8'b01_??????: next_code = OP_SUB;   // branch compare
            8'b11_??????: next_code = OP_OR;    // immediate logical ops
            8'b10_100000: next_code = OP_ADD;
            8'b10_100010: next_code = OP_SUB;
            8'b10_100100: next_code = OP_AND;
            8'b10_100101: next_code = OP_OR;
            8'b10_100110: next_code = OP_XOR;
            8'b10_100111: next_code = OP_NOR;
            8'b10_101010: next_code = OP_SLT;
            8'b10_000000: next_code = OP_SLL;
            default:      next_code = OP_ADD;
        endcase
    end

    // Output register. Reset forces ADD immediately, without a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            saida <= OP_ADD;
        end else begin
            saida <= next_code;
        end
    end

endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: scoreboard bench for alu_control.
// Inputs change on the falling edge; the expected code is queued at that
// point and popped about 1 time unit after the next rising edge.
module tb_alu_control;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [5:0] funct = 6'b100010;
    logic [1:0] ALUOp = 2'b10;
    logic [2:0] saida;

    logic [2:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;

    alu_control dut (
        .clock  (clock),
        .reset_n(reset_n),
        .funct  (funct),
        .ALUOp  (ALUOp),
        .saida  (saida)
    );

    // 10-unit clock period
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: saida=%b expected=%b (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference decode, written directly from the operation tables.
    function automatic logic [2:0] model(input logic [1:0] op, input logic [5:0] f);
        logic [2:0] r;
        if (op == 2'b00)      r = 3'b010;
        else if (op == 2'b01) r = 3'b110;
        else if (op == 2'b11) r = 3'b001;
        else begin
            case (f)
                6'b100000: r = 3'b010;
                6'b100010: r = 3'b110;
                6'b100100: r = 3'b000;
                6'b100101: r = 3'b001;
                6'b100110: r = 3'b011;
                6'b100111: r = 3'b100;
                6'b101010: r = 3'b111;
                6'b000000: r = 3'b101;
                default:   r = 3'b010;
            endcase
        end
        return r;
    endfunction

    // Pop one expected code and compare it with the current output.
    task automatic score(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: saida=%b expected=<empty queue>", tag, saida);
        end else begin
            check(tag, saida, exp_q.pop_front());
        end
    endtask

    // Apply one input pair at the falling edge and score it after the next rising edge.
    task automatic drive(input logic [1:0] op, input logic [5:0] f, input string tag);
        @(negedge clock);
        ALUOp = op;
        funct = f;
        exp_q.push_back(model(op, f));
        @(posedge clock);
        #1;
        score(tag);
    endtask

    logic [5:0] sweep_f[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b100110, 6'b100111, 6'b101010, 6'b000000};
    logic [2:0] sweep_e[8] = '{3'b010, 3'b110, 3'b000, 3'b001,
                               3'b011, 3'b100, 3'b111, 3'b101};

    initial begin
        // Reset: the output must be forced to ADD without a clock edge.
        #2 reset_n = 1'b0;
        #1 check("reset_async", saida, 3'b010);
        repeat (3) begin
            @(posedge clock);
            #1 check("reset_hold", saida, 3'b010);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1 check("release_hold", saida, 3'b010);
        exp_q.push_back(3'b110);
        @(posedge clock);
        #1 score("release_first_edge");

        // Basic sequence, then funct ignored for the non-R classes.
        drive(2'b10, 6'b100000, "rtype_add");
        drive(2'b01, 6'b100000, "aluop01_sub");
        drive(2'b00, 6'b101010, "aluop00_add");
        drive(2'b11, 6'b101010, "aluop11_or");

        // Full R-type sweep; the bench's table also cross-checks the model.
        for (int i = 0; i < 8; i++) begin
            check("sweep_model", model(2'b10, sweep_f[i]), sweep_e[i]);
            drive(2'b10, sweep_f[i], $sformatf("sweep_%b", sweep_f[i]));
        end
        drive(2'b10, 6'b111111, "undef_funct");

        // Mid-cycle input changes must not reach the output before an edge.
        #2;
        ALUOp = 2'b01;
        funct = 6'b100111;
        #2 check("midcycle_stable", saida, 3'b010);
        exp_q.push_back(model(2'b01, 6'b100111));
        @(posedge clock);
        #1 score("midcycle_next_edge");

        // Mid-cycle reset: immediate ADD, decoding resumes after release.
        ALUOp = 2'b10;
        funct = 6'b101010;
        #1 reset_n = 1'b0;
        #1 check("midcycle_reset", saida, 3'b010);
        @(posedge clock);
        #1 check("midcycle_reset_hold", saida, 3'b010);
        @(negedge clock);
        reset_n = 1'b1;
        drive(2'b10, 6'b100010, "after_reset_sub");

        // Randomised stimulus, biased toward the defined R-type functs.
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) f = sweep_f[$urandom_range(0, 7)];
            else                           f = 6'($urandom_range(0, 63));
            drive(op, f, "random");
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
